keccak_pi_inv_stream: RTL and testbench



---
 rtl/keccak_pi_inv_stream.sv | 127 ++++++++++++
 tb/tb_keccak_pi_inv_stream.sv | 249 ++++++++++++++++++++++++
 2 files changed

// File: rtl/keccak_pi_inv_stream.sv
// Lane-serial inverse-Pi permutation for Keccak-f[1600]: buffers 25 lanes, then re-emits them permuted.
// Optional KECCAK_PI_DIR_EN adds a dir port and the forward-Pi map (dir=1).
module keccak_pi_inv_stream #(
    parameter int LANE_W  = 64,
    parameter int N_LANES = 25
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              s_lane_valid,
    output logic              s_lane_ready,
    input  logic [0:LANE_W-1] s_lane,
    output logic              m_lane_valid,
    input  logic              m_lane_ready,
    output logic [0:LANE_W-1] m_lane,
    output logic              m_lane_last,
    output logic              busy
`ifdef KECCAK_PI_DIR_EN
    ,
    input  logic              dir
`endif
);

    localparam int CNT_W = $clog2(N_LANES);
    typedef logic [CNT_W-1:0] cnt_t;
    localparam cnt_t LAST = cnt_t'(N_LANES - 1);

    // Output k = 5y+x reads lane 5*((2x+3y) mod 5) + y.
    localparam cnt_t INV_MAP [N_LANES] = '{
        5'd0,  5'd10, 5'd20, 5'd5,  5'd15,
        5'd16, 5'd1,  5'd11, 5'd21, 5'd6,
        5'd7,  5'd17, 5'd2,  5'd12, 5'd22,
        5'd23, 5'd8,  5'd18, 5'd3,  5'd13,
        5'd14, 5'd24, 5'd9,  5'd19, 5'd4
    };

`ifdef KECCAK_PI_DIR_EN
    // Output k = 5y+x reads lane 5x + ((x+3y) mod 5).
    localparam cnt_t FWD_MAP [N_LANES] = '{
        5'd0,  5'd6,  5'd12, 5'd18, 5'd24,
        5'd3,  5'd9,  5'd10, 5'd16, 5'd22,
        5'd1,  5'd7,  5'd13, 5'd19, 5'd20,
        5'd4,  5'd5,  5'd11, 5'd17, 5'd23,
        5'd2,  5'd8,  5'd14, 5'd15, 5'd21
    };
    logic dir_q;
`endif

    typedef enum logic {LOAD, EMIT} state_t;

    state_t            state;
    cnt_t              in_cnt;
    cnt_t              out_cnt;
    cnt_t              src;
    logic [0:LANE_W-1] lane_buf [N_LANES];

    wire s_hs = s_lane_valid & s_lane_ready;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state        <= LOAD;
            in_cnt       <= '0;
            out_cnt      <= '0;
            s_lane_ready <= 1'b1;
            m_lane_valid <= 1'b0;
            busy         <= 1'b0;
`ifdef KECCAK_PI_DIR_EN
            dir_q        <= 1'b0;
`endif
        end else begin
            case (state)
                LOAD: begin
                    if (s_hs) begin
                        busy <= 1'b1;
                        if (in_cnt == LAST) begin
                            in_cnt       <= '0;
                            state        <= EMIT;
                            s_lane_ready <= 1'b0;
                            m_lane_valid <= 1'b1;
`ifdef KECCAK_PI_DIR_EN
                            dir_q        <= dir;
`endif
                        end else begin
                            in_cnt <= in_cnt + 1'b1;
                        end
                    end
                end
                EMIT: begin
                    if (m_lane_ready) begin
                        if (out_cnt == LAST) begin
                            out_cnt      <= '0;
                            state        <= LOAD;
                            s_lane_ready <= 1'b1;
                            m_lane_valid <= 1'b0;
                            busy         <= 1'b0;
                        end else begin
                            out_cnt <= out_cnt + 1'b1;
                        end
                    end
                end
                default: state <= LOAD;
            endcase
        end
    end

    // Lane storage carries data only, so it is left out of reset.
    always_ff @(posedge clk) begin
        if (s_hs) begin
            lane_buf[in_cnt] <= s_lane;
        end
    end

    always_comb begin
        src = INV_MAP[out_cnt];
`ifdef KECCAK_PI_DIR_EN
        if (dir_q) begin
            src = FWD_MAP[out_cnt];
        end
`endif
        m_lane = '0;
        if (m_lane_valid) begin
            m_lane = lane_buf[src];
        end
    end

    assign m_lane_last = m_lane_valid & (out_cnt == LAST);

endmodule

// File: tb/tb_keccak_pi_inv_stream.sv
// Scoreboard bench for keccak_pi_inv_stream: stimulus pushes expected lanes, a negedge monitor pops and compares.
module tb_keccak_pi_inv_stream;

    logic        clk = 1'b0;
    logic        rst;
    logic        s_lane_valid;
    logic        s_lane_ready;
    logic [0:63] s_lane;
    logic        m_lane_valid;
    logic        m_lane_ready;
    logic [0:63] m_lane;
    logic        m_lane_last;
    logic        busy;
`ifdef KECCAK_PI_DIR_EN
    logic        dir;
`endif

    keccak_pi_inv_stream #(.LANE_W(64), .N_LANES(25)) dut (
        .clk          (clk),
        .rst          (rst),
        .s_lane_valid (s_lane_valid),
        .s_lane_ready (s_lane_ready),
        .s_lane       (s_lane),
        .m_lane_valid (m_lane_valid),
        .m_lane_ready (m_lane_ready),
        .m_lane       (m_lane),
        .m_lane_last  (m_lane_last),
        .busy         (busy)
`ifdef KECCAK_PI_DIR_EN
        ,
        .dir          (dir)
`endif
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [63:0] lane;
        logic        last;
    } exp_t;

    exp_t        q [$];
    int          errors = 0;
    int          checks = 0;
    bit          bp_on  = 1'b0;
    logic [63:0] st   [25];
    logic [63:0] orig [25];

    // Hand-derived source lanes for each output position.
    int INV_EXP [25] = '{0, 10, 20, 5, 15, 16, 1, 11, 21, 6, 7, 17, 2, 12, 22,
                         23, 8, 18, 3, 13, 14, 24, 9, 19, 4};
`ifdef KECCAK_PI_DIR_EN
    int FWD_EXP [25] = '{0, 6, 12, 18, 24, 3, 9, 10, 16, 22, 1, 7, 13, 19, 20,
                         4, 5, 11, 17, 23, 2, 8, 14, 15, 21};
`endif

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %h, required %h", name, act, req);
        end
    endtask

    // mode 0: inverse Pi of st; mode 1: orig (round trip); mode 2: forward Pi of st
    task automatic push_exp(input int mode);
        exp_t e;
        for (int k = 0; k < 25; k++) begin
            e.last = (k == 24);
            case (mode)
                1:       e.lane = orig[k];
`ifdef KECCAK_PI_DIR_EN
                2:       e.lane = st[FWD_EXP[k]];
`endif
                default: e.lane = st[INV_EXP[k]];
            endcase
            q.push_back(e);
        end
    endtask

    task automatic load_state(input int n, input bit gaps, input bit hold_valid);
        for (int i = 0; i < n; i++) begin
            int t = 0;
            bit done = 1'b0;
            if (gaps && i > 0) begin
                s_lane_valid = 1'b0;
                @(posedge clk); #1;
            end
            s_lane_valid = 1'b1;
            s_lane       = st[i];
            while (!done) begin
                @(negedge clk);
                done = s_lane_ready;
                @(posedge clk); #1;
                t++;
                if (t > 2000) begin
                    $display("FAIL load_timeout: lane %0d never accepted", i);
                    $fatal(1, "input handshake timeout");
                end
            end
        end
        if (hold_valid) begin
            s_lane = 64'hDEAD_BEEF_0BAD_F00D;
        end else begin
            s_lane_valid = 1'b0;
        end
        if (n == 25) begin
            @(negedge clk);
            chk("first_out_latency", {63'd0, m_lane_valid}, 64'd1);
        end
    endtask

    task automatic drain;
        int t = 0;
        while (q.size() != 0) begin
            @(posedge clk);
            t++;
            if (t > 5000) begin
                $display("FAIL drain_timeout: %0d lanes still expected", q.size());
                $fatal(1, "output timeout");
            end
        end
        #1;
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_s_ready"}, {63'd0, s_lane_ready}, 64'd1);
        chk({tag, "_m_valid"}, {63'd0, m_lane_valid}, 64'd0);
        chk({tag, "_m_lane"},  m_lane,                64'd0);
        chk({tag, "_m_last"},  {63'd0, m_lane_last},  64'd0);
        chk({tag, "_busy"},    {63'd0, busy},         64'd0);
    endtask

    always @(posedge clk) begin
        #1;
        m_lane_ready = bp_on ? 1'($urandom_range(0, 1)) : 1'b1;
    end

    // Monitor: stall stability, phase exclusion and scoreboard comparison.
    logic [63:0] prev_lane;
    logic        prev_last;
    bit          stalled = 1'b0;
    always @(negedge clk) begin
        exp_t e;
        if (m_lane_valid) begin
            chk("s_ready_in_emit", {63'd0, s_lane_ready}, 64'd0);
            chk("busy_in_emit", {63'd0, busy}, 64'd1);
            if (stalled) begin
                chk("stall_lane", m_lane, prev_lane);
                chk("stall_last", {63'd0, m_lane_last}, {63'd0, prev_last});
            end
            if (m_lane_ready) begin
                stalled = 1'b0;
                if (q.size() == 0) begin
                    chk("unexpected_lane", m_lane, 64'hX);
                end else begin
                    e = q.pop_front();
                    chk("lane", m_lane, e.lane);
                    chk("last", {63'd0, m_lane_last}, {63'd0, e.last});
                end
            end else begin
                stalled   = 1'b1;
                prev_lane = m_lane;
                prev_last = m_lane_last;
            end
        end else begin
            stalled = 1'b0;
            chk("idle_lane_zero", m_lane, 64'd0);
            chk("idle_last_zero", {63'd0, m_lane_last}, 64'd0);
        end
    end

    initial begin
        rst          = 1'b1;
        s_lane_valid = 1'b0;
        s_lane       = '0;
        m_lane_ready = 1'b1;
`ifdef KECCAK_PI_DIR_EN
        dir          = 1'b0;
`endif
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_reset_outputs("reset");
        @(posedge clk); #1;
        rst = 1'b0;

        // Lane i = i, no stalls
        for (int i = 0; i < 25; i++) st[i] = 64'(i);
        push_exp(0);
        load_state(25, 1'b0, 1'b0);
        drain();

        // Same state under random backpressure
        bp_on = 1'b1;
        push_exp(0);
        load_state(25, 1'b0, 1'b0);
        drain();
        bp_on = 1'b0;

        // Input gaps, s_lane_valid left high through EMIT
        push_exp(0);
        load_state(25, 1'b1, 1'b1);
        drain();
        s_lane_valid = 1'b0;

        // Abort mid-load with rst, then a fresh state
        for (int i = 0; i < 25; i++) st[i] = 64'hFFFF_0000_0000_0000 | 64'(i);
        load_state(12, 1'b0, 1'b0);
        rst = 1'b1;
        #1;
        check_reset_outputs("async_reset");
        @(posedge clk); #1;
        rst = 1'b0;
        for (int i = 0; i < 25; i++) st[i] = {$urandom, $urandom};
        push_exp(0);
        load_state(25, 1'b0, 1'b0);
        drain();

`ifdef KECCAK_PI_DIR_EN
        // Forward map; dir flipped during EMIT must not matter
        for (int i = 0; i < 25; i++) st[i] = 64'(i);
        dir = 1'b1;
        push_exp(2);
        load_state(25, 1'b0, 1'b0);
        dir = 1'b0;
        drain();
`endif

        // Round trip: forward Pi A'[x][y] = A[(x+3y)%5][x], then this unit
        bp_on = 1'b1;
        for (int n = 0; n < 100; n++) begin
            for (int i = 0; i < 25; i++) orig[i] = {$urandom, $urandom};
            for (int y = 0; y < 5; y++)
                for (int x = 0; x < 5; x++)
                    st[5*y + x] = orig[5*x + ((x + 3*y) % 5)];
            push_exp(1);
            load_state(25, 1'b0, 1'b0);
            drain();
        end
        bp_on = 1'b0;

        @(negedge clk);
        chk("final_busy", {63'd0, busy}, 64'd0);
        chk("final_s_ready", {63'd0, s_lane_ready}, 64'd1);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
